// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Gap counter width: enough to count GAP_CYC cycles, never narrower than 1 bit.
  function automatic int gap_cnt_w(input int gap_cyc);
    return (gap_cyc > 0) ? $clog2(gap_cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/shift_seq_reg.sv
// N-bit universal shift register: hold, shift right, shift left or parallel load.
// Serial fill on both ends is 0.
module shift_seq_reg
  import shift_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   mode,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_d;
  logic [N-1:0] q_q;

  // Next register contents selected by the mode code.
  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_RIGHT: q_d = {1'b0, q_q[N-1:1]};
      MODE_LEFT:  q_d = {q_q[N-2:0], 1'b0};
      MODE_LOAD:  q_d = d;
      default:    q_d = q_q;
    endcase
  end

  // Register storage, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial transmit sequencer: accepts a word per handshake, then
// drives the shift register to emit it one bit per cycle, MSB- or LSB-first,
// with stall support and an optional idle gap between words.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int N       = 8,
  parameter int GAP_CYC = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         msb_first,
  input  logic         stall,
  output logic         sout,
  output logic         sout_valid,
  output logic         done,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam int GW = gap_cnt_w(GAP_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           dir_q, dir_d;
  logic [1:0]     mode;
  logic [N-1:0]   sr_q;
  logic           accept;
  logic           last_bit;

  shift_seq_reg #(.N(N)) u_reg (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .d     (in_data),
    .q     (sr_q)
  );

  // Next-state, counter, shift-mode and handshake decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    dir_d      = dir_q;
    mode       = MODE_HOLD;
    in_ready   = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;
    last_bit   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        sout_valid = !stall;
        last_bit   = !stall && (cnt_q == CNT_LAST);
        done       = last_bit;
        // Back-to-back reload is only possible when no gap is configured.
        in_ready   = last_bit && (GAP_CYC == 0);
        if (!stall) begin
          mode  = dir_q ? MODE_LEFT : MODE_RIGHT;
          cnt_d = cnt_q + 1'b1;
        end
        if (last_bit) begin
          cnt_d = '0;
          if (GAP_CYC > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A load overrides any shift decided above, including the last-bit reload.
    accept = in_valid && in_ready;
    if (accept) begin
      mode    = MODE_LOAD;
      dir_d   = msb_first;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      dir_q   <= dir_d;
    end
  end

  assign sout = dir_q ? sr_q[N-1] : sr_q[0];
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: two instances (no gap, 3-cycle gap)
// driven concurrently; accepted words push their expected bit stream, and a
// per-instance monitor pops and checks every cycle.
`timescale 1ns/1ps
module tb_shift_seq_ctrl;

  localparam int N = 8;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst        [2];
  logic [N-1:0] in_data    [2];
  logic         in_valid   [2];
  logic         msb_first  [2];
  logic         stall      [2];
  logic         in_ready   [2];
  logic         sout       [2];
  logic         sout_valid [2];
  logic         done       [2];
  logic         busy       [2];

  exp_t exp_q     [2][$];
  logic stall_pat [2][$];
  bit   stall_en  [2];
  int   gap_left  [2];
  bit   after_rst [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, g, $time, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int GC = (g == 0) ? 0 : 3;

    shift_seq_ctrl #(.N(N), .GAP_CYC(GC)) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .in_data    (in_data[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .msb_first  (msb_first[g]),
      .stall      (stall[g]),
      .sout       (sout[g]),
      .sout_valid (sout_valid[g]),
      .done       (done[g]),
      .busy       (busy[g])
    );

    // Stall source: directed pattern first, otherwise random when enabled.
    initial begin : stall_drv
      stall[g] = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (stall_pat[g].size() > 0) stall[g] = stall_pat[g].pop_front();
        else stall[g] = stall_en[g] && ($urandom_range(0, 3) == 0);
      end
    end

    // Monitor: reference model of pending bits and gap cycles.
    always @(negedge clk) begin : mon
      int   sz;
      logic e_valid, e_ready, e_busy, e_done;
      exp_t f;
      if (rst[g]) begin
        exp_q[g].delete();
        gap_left[g] = 0;
        after_rst[g] = 1'b1;
      end else begin
        sz      = exp_q[g].size();
        e_valid = (sz > 0) && !stall[g];
        e_ready = (sz == 0 && gap_left[g] == 0) || (sz == 1 && !stall[g] && GC == 0);
        e_busy  = (sz > 0) || (gap_left[g] > 0);
        e_done  = 1'b0;
        if (sz > 0) e_done = e_valid && exp_q[g][0].last;
        chk("sout_valid", g, 32'(sout_valid[g]), 32'(e_valid));
        chk("in_ready", g, 32'(in_ready[g]), 32'(e_ready));
        chk("busy", g, 32'(busy[g]), 32'(e_busy));
        chk("done", g, 32'(done[g]), 32'(e_done));
        if (sz > 0) begin
          chk("sout", g, 32'(sout[g]), 32'(exp_q[g][0].b));
          after_rst[g] = 1'b0;
        end else if (after_rst[g]) begin
          chk("sout_idle", g, 32'(sout[g]), 32'd0);
        end
        if (e_valid) begin
          f = exp_q[g].pop_front();
          if (f.last && GC > 0) gap_left[g] = GC;
        end else if (sz == 0 && gap_left[g] > 0) begin
          gap_left[g]--;
        end
      end
    end
  end

  // Offer a word until accepted; on accept push its expected bit stream.
  task automatic send(input int g, input logic [N-1:0] d, input logic m,
                      input int stall_after, input bit keep);
    bit acc;
    int guard;
    in_data[g]   = d;
    msb_first[g] = m;
    in_valid[g]  = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready[g] && !rst[g];
      @(posedge clk);
      guard++;
    end
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        exp_q[g].push_back('{b: (m ? d[N-1-i] : d[i]), last: (i == N - 1)});
      end
      if (stall_after >= 0) begin
        repeat (stall_after) stall_pat[g].push_back(1'b0);
        repeat (3) stall_pat[g].push_back(1'b1);
      end
    end else begin
      chk("accept_timeout", g, 32'd0, 32'd1);
    end
    #1;
    if (!keep) begin
      in_valid[g]  = 1'b0;
      in_data[g]   = N'($urandom);
      msb_first[g] = 1'($urandom);
    end
  endtask

  task automatic wait_idle(input int g);
    int guard;
    guard = 0;
    while ((exp_q[g].size() != 0 || gap_left[g] != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("idle_timeout", g, 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic random_words(input int g, input int count);
    bit keep;
    stall_en[g] = 1'b1;
    for (int k = 0; k < count; k++) begin
      keep = ($urandom_range(0, 2) != 0);
      send(g, N'($urandom), 1'($urandom), -1, keep);
      if (!keep) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    in_valid[g] = 1'b0;
    stall_en[g] = 1'b0;
    wait_idle(g);
  endtask

  task automatic run0();
    rst[0] = 1'b1; in_valid[0] = 1'b0; in_data[0] = '0; msb_first[0] = 1'b0; stall_en[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    send(0, 8'h1E, 1'b1, -1, 1'b0); wait_idle(0);
    send(0, 8'h1E, 1'b0, -1, 1'b0); wait_idle(0);
    send(0, 8'hFF, 1'b1, -1, 1'b1);
    send(0, 8'h00, 1'b1, -1, 1'b0); wait_idle(0);
    send(0, 8'hA5, 1'b1, 2, 1'b0);  wait_idle(0);
    send(0, 8'hF0, 1'b1, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    send(0, 8'h3C, 1'b0, -1, 1'b0); wait_idle(0);
    random_words(0, 150);
  endtask

  task automatic run1();
    rst[1] = 1'b1; in_valid[1] = 1'b0; in_data[1] = '0; msb_first[1] = 1'b0; stall_en[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst[1] = 1'b0;
    send(1, 8'h5A, 1'b1, -1, 1'b1);
    send(1, 8'hC3, 1'b0, -1, 1'b1);
    send(1, 8'h81, 1'b1, -1, 1'b0); wait_idle(1);
    random_words(1, 60);
  endtask

  initial begin
    fork
      run0();
      run1();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
